// File: rtl/rice_core_pkg.sv
// ----------------------------------------------------------------------------
// rice_core_pkg
// Shared pipeline types and fetch-buffer constants for the rice core.
//
// The pipeline types depend on the register width, so they are produced by the
// RICE_CORE_DEFINE_TYPES(xlen) macro. A parameterised module or interface
// invokes the macro with its own XLEN. The package itself carries the default
// 32-bit flavour for code that is not width-parameterised.
//
// Contents:
//   rice_core_pc         - program counter, xlen bits
//   rice_core_inst       - 32-bit instruction word
//   rice_core_if_result  - {valid, pc, inst} handed from IF to ID
//   FETCH_BUFFER_DEPTH   - number of in-flight fetch slots (2)
//   FETCH_BUFFER_PTR_W   - slot pointer width
//   FETCH_BUFFER_COUNT_W - width of a 0..DEPTH occupancy counter
// ----------------------------------------------------------------------------
`ifndef RICE_CORE_PKG_SV
`define RICE_CORE_PKG_SV

`define RICE_CORE_DEFINE_TYPES(xlen) \
    typedef logic [(xlen)-1:0] rice_core_pc; \
    typedef logic [31:0] rice_core_inst; \
    typedef struct packed { \
        logic          valid; \
        rice_core_pc   pc; \
        rice_core_inst inst; \
    } rice_core_if_result;

package rice_core_pkg;

    // Width of a counter or pointer, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

    localparam int FETCH_BUFFER_DEPTH   = 2;
    localparam int FETCH_BUFFER_PTR_W   = clog2_min1(FETCH_BUFFER_DEPTH);
    localparam int FETCH_BUFFER_COUNT_W = clog2_min1(FETCH_BUFFER_DEPTH + 1);
    localparam int INST_BYTES           = 4;

    `RICE_CORE_DEFINE_TYPES(32)

endpackage

`endif

// File: rtl/rice_core_if_stage_if.sv
// ----------------------------------------------------------------------------
// pipeline_if
// Link between the fetch (IF) stage and the decode (ID) stage.
//
// Signals:
//   stall     - ID -> IF : hold the current if_result, do not consume it
//   flush     - ID -> IF : redirect fetch to flush_pc and drop everything
//   flush_pc  - ID -> IF : redirect target (low two bits ignored by IF)
//   if_result - IF -> ID : {valid, pc, inst} of the oldest fetched instruction
//
// Modports:
//   if_stage - the fetch side
//   id_stage - the decode side
// ----------------------------------------------------------------------------
interface pipeline_if #(
    parameter int XLEN = 32
);
    import rice_core_pkg::*;

    `RICE_CORE_DEFINE_TYPES(XLEN)

    logic               stall;
    logic               flush;
    rice_core_pc        flush_pc;
    rice_core_if_result if_result;

    modport if_stage (
        input  stall,
        input  flush,
        input  flush_pc,
        output if_result
    );

    modport id_stage (
        output stall,
        output flush,
        output flush_pc,
        input  if_result
    );

endinterface

// File: rtl/rice_core_fetch_buffer.sv
// ----------------------------------------------------------------------------
// rice_core_fetch_buffer
// In-order slot buffer for outstanding instruction fetches.
//
// A slot is allocated when a request is accepted (the PC is recorded). It is
// filled when the matching response returns (the instruction is recorded). It
// is freed when the decode stage consumes it. Allocation, filling and reading
// each walk the slots in the same circular order, so responses pair with
// requests purely by position.
//
// Ports:
//   clk, srst      - clock, synchronous active-high reset
//   clear          - drop every slot (fetch redirect); beats all other controls
//   alloc/alloc_pc - allocate the next slot for a request at alloc_pc
//   fill/fill_inst - write the instruction into the oldest unfilled slot
//   consume        - free the oldest slot
//   has_free_slot  - at least one slot was free at the start of this cycle
//   pending_count  - slots allocated but not yet filled
//   head_valid     - oldest slot holds an instruction
//   head_pc/inst   - contents of the oldest slot
// ----------------------------------------------------------------------------
module rice_core_fetch_buffer
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            clear,
    input  logic                            alloc,
    input  logic [XLEN-1:0]                 alloc_pc,
    input  logic                            fill,
    input  logic [31:0]                     fill_inst,
    input  logic                            consume,
    output logic                            has_free_slot,
    output logic [FETCH_BUFFER_COUNT_W-1:0] pending_count,
    output logic                            head_valid,
    output logic [XLEN-1:0]                 head_pc,
    output logic [31:0]                     head_inst
);

    localparam int DEPTH = FETCH_BUFFER_DEPTH;

    typedef logic [FETCH_BUFFER_PTR_W-1:0]   ptr_t;
    typedef logic [FETCH_BUFFER_COUNT_W-1:0] count_t;

    ptr_t   alloc_ptr_reg;
    ptr_t   fill_ptr_reg;
    ptr_t   read_ptr_reg;
    count_t used_reg;     // allocated slots, filled or not
    count_t pending_reg;  // allocated slots still waiting for their response

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    function automatic ptr_t ptr_inc(input ptr_t ptr);
        return (ptr == ptr_t'(DEPTH - 1)) ? '0 : ptr + ptr_t'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            read_ptr_reg  <= '0;
            used_reg      <= '0;
            pending_reg   <= '0;
        end else begin
            if (alloc) begin
                alloc_ptr_reg <= ptr_inc(alloc_ptr_reg);
            end
            if (fill) begin
                fill_ptr_reg <= ptr_inc(fill_ptr_reg);
            end
            if (consume) begin
                read_ptr_reg <= ptr_inc(read_ptr_reg);
            end
            used_reg    <= used_reg + count_t'(alloc) - count_t'(consume);
            pending_reg <= pending_reg + count_t'(alloc) - count_t'(fill);
        end
    end

    // Slot storage. A clear only rewinds the pointers; stale contents are
    // unreachable until they are overwritten by a later allocate/fill.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (!clear) begin
            if (alloc) begin
                pc_mem[alloc_ptr_reg] <= alloc_pc;
            end
            if (fill) begin
                inst_mem[fill_ptr_reg] <= fill_inst;
            end
        end
    end

    // Freeness comes from registered occupancy only, so a slot consumed this
    // cycle cannot be re-allocated until the next one.
    assign has_free_slot = (used_reg < count_t'(DEPTH));
    assign pending_count = pending_reg;

    // Filled slots are exactly the used ones that are not pending, and they
    // sit in front of the pending ones, so the head is filled iff any are.
    assign head_valid = (used_reg != pending_reg);
    assign head_pc    = pc_mem[read_ptr_reg];
    assign head_inst  = inst_mem[read_ptr_reg];

endmodule

// File: rtl/rice_core_if_stage.sv
// ----------------------------------------------------------------------------
// rice_core_if_stage
// Instruction fetch stage: issues word-aligned fetch requests and hands the
// returned instructions to decode in program order.
//
// Parameters:
//   XLEN     - register / PC width
//   RESET_PC - first fetch address after reset (low two bits ignored)
//
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   o_inst_request_valid    - fetch request valid
//   i_inst_request_ready    - memory accepts the request this cycle
//   o_inst_request_address  - fetch address, always word aligned
//   i_inst_response_valid   - instruction returned (in request order)
//   i_inst_response_data    - instruction word
//   pipeline                - stall/flush/flush_pc in, if_result out
//
// After a flush, responses still in flight for the abandoned requests are
// counted in a discard counter and dropped as they arrive. No new request is
// issued until that counter drains, which keeps responses paired by order.
// ----------------------------------------------------------------------------
module rice_core_if_stage
    import rice_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_inst_request_valid,
    input  logic            i_inst_request_ready,
    output logic [XLEN-1:0] o_inst_request_address,
    input  logic            i_inst_response_valid,
    input  logic [31:0]     i_inst_response_data,
    pipeline_if.if_stage    pipeline
);

    `RICE_CORE_DEFINE_TYPES(XLEN)

    typedef logic [FETCH_BUFFER_COUNT_W-1:0] count_t;

    localparam rice_core_pc PC_ALIGN_MASK = ~rice_core_pc'(INST_BYTES - 1);

    rice_core_pc   fetch_pc_reg;
    count_t        discard_reg;

    logic          has_free_slot;
    count_t        pending_count;
    logic          head_valid;
    rice_core_pc   head_pc;
    rice_core_inst head_inst;

    logic          request_accept;
    logic          response_fill;
    logic          response_drop;
    logic          consume;

    assign o_inst_request_valid   = !i_rst && has_free_slot && !pipeline.flush
                                    && (discard_reg == '0);
    assign o_inst_request_address = fetch_pc_reg;

    assign request_accept = o_inst_request_valid && i_inst_request_ready;
    assign response_fill  = i_inst_response_valid && (discard_reg == '0);
    assign response_drop  = i_inst_response_valid && (discard_reg != '0);
    assign consume        = head_valid && !pipeline.stall && !pipeline.flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_reg <= RESET_PC & PC_ALIGN_MASK;
            discard_reg  <= '0;
        end else if (pipeline.flush) begin
            fetch_pc_reg <= pipeline.flush_pc & PC_ALIGN_MASK;
            // Every response still owed is stale. A response arriving right
            // now settles one of them, whether it would have filled a slot
            // or was already being discarded.
            discard_reg  <= discard_reg + pending_count
                            - count_t'(i_inst_response_valid);
        end else begin
            if (request_accept) begin
                fetch_pc_reg <= fetch_pc_reg + rice_core_pc'(INST_BYTES);
            end
            if (response_drop) begin
                discard_reg <= discard_reg - count_t'(1);
            end
        end
    end

    rice_core_fetch_buffer #(
        .XLEN (XLEN)
    ) u_fetch_buffer (
        .clk           (i_clk),
        .srst          (i_rst),
        .clear         (pipeline.flush),
        .alloc         (request_accept),
        .alloc_pc      (fetch_pc_reg),
        .fill          (response_fill),
        .fill_inst     (i_inst_response_data),
        .consume       (consume),
        .has_free_slot (has_free_slot),
        .pending_count (pending_count),
        .head_valid    (head_valid),
        .head_pc       (head_pc),
        .head_inst     (head_inst)
    );

    assign pipeline.if_result = '{valid: head_valid, pc: head_pc, inst: head_inst};

    // A response with nothing outstanding and nothing to discard means the
    // memory side broke the in-order, one-response-per-request contract.
    orphan_response_check : assert property (
        @(posedge i_clk) disable iff (i_rst)
        !(i_inst_response_valid && (discard_reg == '0) && (pending_count == '0))
    );

endmodule

// File: tb/tb_rice_core_if_stage.sv
// ----------------------------------------------------------------------------
// tb_rice_core_if_stage
// Self-checking bench for rice_core_if_stage: an in-order memory with
// configurable latency, a queue-level reference model compared every cycle,
// a gap-free program-order scoreboard, and directed scenarios with literal
// expectations.
// ----------------------------------------------------------------------------
module tb_rice_core_if_stage;
    import rice_core_pkg::*;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;

    always #5 clk = ~clk;

    pipeline_if #(.XLEN(XLEN)) pipe ();

    rice_core_if_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .o_inst_request_valid   (req_valid),
        .i_inst_request_ready   (req_ready),
        .o_inst_request_address (req_addr),
        .i_inst_response_valid  (resp_valid),
        .i_inst_response_data   (resp_data),
        .pipeline               (pipe)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Per-cycle drive values set by the scenarios.
    bit          rst_d      = 1'b1;
    bit          ready_d    = 1'b1;
    bit          stall_d    = 1'b0;
    bit          flush_d    = 1'b0;
    logic [31:0] flush_pc_d = '0;
    int          lat_min    = 1;
    int          lat_max    = 1;

    // Memory: in-order responses, one per cycle at most.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;
    mem_req_t mem_q[$];
    int       last_due = -1;

    // Reference model of the fetch stage.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_pc[$];
    logic [31:0] m_inst[$];
    bit          m_filled[$];
    int          m_discard;

    // Program-order scoreboard.
    logic [31:0] exp_next_pc;
    int          consumed;

    // DUT values seen in the latest step, and logs for directed checks.
    logic        obs_req_valid;
    logic [31:0] obs_addr;
    logic        obs_if_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_inst;
    logic [31:0] req_log[$];
    logic [31:0] res_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cycle, act, exp);
        end
    endtask

    // One clock cycle: drive, compare, advance model and memory, clock.
    task automatic step();
        bit          resp;
        logic [31:0] rdata;
        bit          m_req;
        bit          m_ifv;
        bit          accept;
        int          unfilled;
        int          idx;
        int          due;

        resp  = !rst_d && (mem_q.size() > 0) && (mem_q[0].due <= cycle);
        rdata = resp ? mem_word(mem_q[0].addr) : 32'h0;

        rst           = rst_d;
        req_ready     = ready_d;
        resp_valid    = resp;
        resp_data     = rdata;
        pipe.stall    = stall_d;
        pipe.flush    = flush_d;
        pipe.flush_pc = flush_pc_d;
        #1;

        obs_req_valid = req_valid;
        obs_addr      = req_addr;
        obs_if_valid  = pipe.if_result.valid;
        obs_pc        = pipe.if_result.pc;
        obs_inst      = pipe.if_result.inst;

        m_req = !rst_d && (m_pc.size() < 2) && !flush_d && (m_discard == 0);
        m_ifv = (m_pc.size() > 0) && m_filled[0];

        check_bit("req_valid", obs_req_valid, m_req);
        if (m_req) check("req_addr", obs_addr, m_fetch_pc);
        if (!rst_d) begin
            check_bit("if_valid", obs_if_valid, m_ifv);
            if (m_ifv) begin
                check("if_pc", obs_pc, m_pc[0]);
                check("if_inst", obs_inst, m_inst[0]);
            end
        end

        accept = obs_req_valid && ready_d;
        if (!rst_d && obs_if_valid && !stall_d && !flush_d) begin
            check("seq_pc", obs_pc, exp_next_pc);
            check("seq_inst", obs_inst, mem_word(obs_pc));
            res_log.push_back(obs_pc);
            exp_next_pc = exp_next_pc + 32'd4;
            consumed++;
        end
        if (!rst_d && accept) req_log.push_back(obs_addr);

        // Model update.
        if (rst_d) begin
            m_fetch_pc = RESET_PC & ~32'h3;
            m_pc.delete();
            m_inst.delete();
            m_filled.delete();
            m_discard   = 0;
            exp_next_pc = m_fetch_pc;
        end else if (flush_d) begin
            unfilled = 0;
            foreach (m_filled[i]) if (!m_filled[i]) unfilled++;
            m_discard = m_discard + unfilled - (resp ? 1 : 0);
            m_pc.delete();
            m_inst.delete();
            m_filled.delete();
            m_fetch_pc  = flush_pc_d & ~32'h3;
            exp_next_pc = m_fetch_pc;
        end else begin
            if (resp) begin
                if (m_discard > 0) begin
                    m_discard--;
                end else begin
                    idx = -1;
                    foreach (m_filled[i]) if (idx < 0 && !m_filled[i]) idx = i;
                    check_bit("resp_has_slot", idx >= 0, 1'b1);
                    if (idx >= 0) begin
                        m_filled[idx] = 1'b1;
                        m_inst[idx]   = rdata;
                    end
                end
            end
            if (m_ifv && !stall_d) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
                void'(m_filled.pop_front());
            end
            if (m_req && ready_d) begin
                m_pc.push_back(m_fetch_pc);
                m_inst.push_back(32'h0);
                m_filled.push_back(1'b0);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        // Memory update.
        if (rst_d) begin
            mem_q.delete();
            last_due = cycle;
        end else begin
            if (resp) void'(mem_q.pop_front());
            if (accept) begin
                due = cycle + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: obs_addr, due: due});
            end
        end

        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_d   = 1'b1;
        ready_d = 1'b1;
        stall_d = 1'b0;
        flush_d = 1'b0;
        step();
        step();
        rst_d = 1'b0;
        req_log.delete();
        res_log.delete();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog cycle=%0d bench did not finish", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int phase_start;
        bit mid_reset_done;

        @(negedge clk);

        // Basic streaming after reset, latency 1.
        lat_min = 1; lat_max = 1;
        do_reset();
        step();  // first cycle out of reset
        check_bit("first_req_valid", obs_req_valid, 1'b1);
        check("first_req_addr", obs_addr, 32'h0000_0100);
        check_bit("reset_if_valid", obs_if_valid, 1'b0);
        check("reset_if_pc", obs_pc, 32'h0);
        check("reset_if_inst", obs_inst, 32'h0);
        step();  // response for 0x100 arrives
        check_bit("fill_cycle_if_valid", obs_if_valid, 1'b0);
        step();  // presented one cycle after the response
        check_bit("present_if_valid", obs_if_valid, 1'b1);
        check("present_if_pc", obs_pc, 32'h0000_0100);
        repeat (5) step();
        check("stream_req0", q_at(req_log, 0), 32'h0000_0100);
        check("stream_req1", q_at(req_log, 1), 32'h0000_0104);
        check("stream_req2", q_at(req_log, 2), 32'h0000_0108);
        check("stream_res0", q_at(res_log, 0), 32'h0000_0100);
        check("stream_res1", q_at(res_log, 1), 32'h0000_0104);
        check("stream_res2", q_at(res_log, 2), 32'h0000_0108);

        // Long stall with both slots full, then flush together with stall.
        do_reset();
        repeat (3) step();
        stall_d = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_bit("stall_req_valid", obs_req_valid, 1'b0);
            check_bit("stall_if_valid", obs_if_valid, 1'b1);
            check("stall_if_pc", obs_pc, 32'h0000_0104);
            check("stall_if_inst", obs_inst, mem_word(32'h0000_0104));
        end
        flush_d = 1'b1; flush_pc_d = 32'h0000_0400;
        step();
        check_bit("flush_cycle_req_valid", obs_req_valid, 1'b0);
        flush_d = 1'b0; stall_d = 1'b0;
        step();
        check_bit("post_flush_if_valid", obs_if_valid, 1'b0);
        check_bit("post_flush_req_valid", obs_req_valid, 1'b1);
        check("post_flush_req_addr", obs_addr, 32'h0000_0400);
        repeat (4) step();
        check("stall_res0", q_at(res_log, 0), 32'h0000_0100);
        check("stall_res1", q_at(res_log, 1), 32'h0000_0400);

        // Flush with two requests in flight at latency 3.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (2) step();
        flush_d = 1'b1; flush_pc_d = 32'h0000_0203;
        step();
        check_bit("disc_flush_req_valid", obs_req_valid, 1'b0);
        flush_d = 1'b0;
        step();
        check_bit("disc_c3_req_valid", obs_req_valid, 1'b0);
        check_bit("disc_c3_if_valid", obs_if_valid, 1'b0);
        step();
        check_bit("disc_c4_req_valid", obs_req_valid, 1'b0);
        step();
        check_bit("disc_c5_req_valid", obs_req_valid, 1'b1);
        check("disc_c5_req_addr", obs_addr, 32'h0000_0200);
        repeat (8) step();
        check("disc_res0", q_at(res_log, 0), 32'h0000_0200);
        check("disc_res1", q_at(res_log, 1), 32'h0000_0204);

        // Address wrap at the top of the space (unaligned redirect target).
        lat_min = 1; lat_max = 1;
        do_reset();
        flush_d = 1'b1; flush_pc_d = 32'hFFFF_FFFE;
        step();
        flush_d = 1'b0;
        repeat (8) step();
        check("wrap_req0", q_at(req_log, 0), 32'hFFFF_FFFC);
        check("wrap_req1", q_at(req_log, 1), 32'h0000_0000);
        check("wrap_res0", q_at(res_log, 0), 32'hFFFF_FFFC);
        check("wrap_res1", q_at(res_log, 1), 32'h0000_0000);

        // Random ready, stall, latency and rare flushes; one mid-run reset.
        lat_min = 1; lat_max = 8;
        do_reset();
        consumed       = 0;
        phase_start    = cycle;
        mid_reset_done = 1'b0;
        while (consumed < 10000 && (cycle - phase_start) < 80000) begin
            ready_d    = ($urandom_range(3, 0) != 0);
            stall_d    = ($urandom_range(3, 0) == 0);
            flush_d    = ($urandom_range(199, 0) == 0);
            flush_pc_d = $urandom;
            rst_d      = 1'b0;
            if (!mid_reset_done && consumed >= 5000) begin
                rst_d          = 1'b1;
                mid_reset_done = 1'b1;
            end
            step();
        end
        rst_d = 1'b0; flush_d = 1'b0; stall_d = 1'b0;
        check_bit("random_progress", consumed >= 10000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
